de_arbiter: RTL and testbench
=============================

DE_ARBITER -- requirements
Module: de_arbiter

Interface
REQ-001 Parameter BURST, default 4, range 1..7: max consecutive de_ack transfers per grant while the other port is waiting.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_req / b_req  input  1  port A/B transfer request, held high until its last ack.
REQ-005 a_ack / b_ack  output  1  port A/B transfer acknowledge, one cycle per transfer.
REQ-006 a_addr / b_addr  input  18  port A/B word address.
REQ-007 a_nbyte / b_nbyte  input  4  port A/B active-low byte enables.
REQ-008 a_rnw / b_rnw  input  1  port A/B read(1)/write(0).
REQ-009 a_w_data / b_w_data  input  32  port A/B write data.
REQ-010 de_req  output  1  frame-store request.
REQ-011 de_ack  input  1  frame-store acknowledge, one cycle per completed transfer.
REQ-012 de_addr  output 18; de_nbyte  output 4; de_rnw  output 1; de_w_data  output 32  frame-store command.
REQ-013 de_r_data  input  32  frame-store read data.
REQ-014 r_data  output  32  de_r_data broadcast to both ports, unregistered.
REQ-015 grant_a / grant_b  output  1  current owner, registered state decode.

Function
REQ-016 States IDLE, GNT_A, GNT_B; registers: state, 3-bit count, 1-bit last (last port granted).
REQ-017 IDLE: de_req=0, de_addr=0, de_nbyte=4'b1111, de_rnw=1, de_w_data=0, both acks 0.
REQ-018 IDLE transition: a_req&b_req -> grant port != last; only one requesting -> that port; none -> stay IDLE.
REQ-019 On entering GNT_x: count<=0, last<=x; grant effective the cycle after the request is sampled (1-cycle arbitration latency).
REQ-020 GNT_x: de_req = x_req, de_addr/de_nbyte/de_rnw/de_w_data = port x inputs, combinational mux.
REQ-021 GNT_x: x_ack = de_ack; other port's ack = 0 always.
REQ-022 Edge in GNT_x with de_ack=1: count<=count+1 (saturating at 7).
REQ-023 Edge in GNT_x with de_ack=1, other port requesting, count+1 >= BURST -> IDLE (forced handover).
REQ-024 Edge in GNT_x with x_req=0 -> IDLE, regardless of de_ack.
REQ-025 Other port idle -> no burst limit; owner keeps grant indefinitely.
REQ-026 Every grant change passes through IDLE for exactly one cycle with de_req=0; GNT_A<->GNT_B direct transitions forbidden.
REQ-027 Simultaneous: de_ack and other-port request rising on the same edge with count+1 >= BURST -> handover taken that edge.
REQ-028 de_ack while in IDLE is ignored: no ack to either port, no state change.
REQ-029 grant_a=(state==GNT_A), grant_b=(state==GNT_B); never both high.

Reset
REQ-030 rst high: immediately state=IDLE, count=0, last=B (port A wins first contention); outputs take IDLE values of REQ-017.
REQ-031 rst asserted mid-transfer aborts the grant; no ack issued; requesters re-arbitrate after release from IDLE.
REQ-032 First arbitration occurs on the first clk edge after rst deasserts.

Verification
REQ-033 Reset release, a_req=b_req=1 same cycle -> grant_a next cycle; after 4 acks -> 1 IDLE cycle, then grant_b.
REQ-034 Only b_req, 10 de_acks -> grant_b held throughout, 10 b_ack pulses, no IDLE gap, de_addr tracks b_addr.
REQ-035 GNT_A, a_addr=18'h12345, a_nbyte=4'b1011, a_rnw=0 -> de_* equal A inputs same cycle; de_ack=1 -> a_ack=1, b_ack=0.
REQ-036 GNT_A, a_req drops after 2 acks, b_req=0 -> IDLE, de_req=0, de_nbyte=4'b1111; later a_req -> GNT_A again.
REQ-037 BURST=1, both requesting -> grant alternates A,IDLE,B,IDLE,... with one ack per grant.
REQ-038 rst pulsed mid-GNT_B with de_ack=1 -> b_ack=0 immediately, state IDLE, next contention granted to A.

Source files
------------

// File: rtl/de_arbiter.sv
// de_arbiter: two-port arbiter sharing one frame-store (DE) port.
// Ports A and B take turns; a busy owner yields after BURST acks
// whenever the other port is waiting, always through one IDLE cycle.
module de_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    output logic        a_ack,
    input  logic [17:0] a_addr,
    input  logic [3:0]  a_nbyte,
    input  logic        a_rnw,
    input  logic [31:0] a_w_data,

    input  logic        b_req,
    output logic        b_ack,
    input  logic [17:0] b_addr,
    input  logic [3:0]  b_nbyte,
    input  logic        b_rnw,
    input  logic [31:0] b_w_data,

    output logic        de_req,
    input  logic        de_ack,
    output logic [17:0] de_addr,
    output logic [3:0]  de_nbyte,
    output logic        de_rnw,
    output logic [31:0] de_w_data,
    input  logic [31:0] de_r_data,

    output logic [31:0] r_data,
    output logic        grant_a,
    output logic        grant_b
);

    localparam int unsigned CW = 3;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;

    logic [CW:0]   count_inc;
    logic          burst_hit;
    logic [CW-1:0] count_sat;

    // Burst accounting: compare the post-ack count, saturate the stored one.
    assign count_inc = {1'b0, count_q} + (CW+1)'(1);
    assign burst_hit = (count_inc >= (CW+1)'(BURST));
    assign count_sat = (count_q == '1) ? count_q : count_inc[CW-1:0];

    // State registers; reset makes A the winner of the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= PORT_B;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitration in IDLE, burst limit / release in GNT_x.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || (last_q == PORT_B))) begin
                    state_d = GNT_A;
                    count_d = '0;
                    last_d  = PORT_A;
                end else if (b_req) begin
                    state_d = GNT_B;
                    count_d = '0;
                    last_d  = PORT_B;
                end
            end
            GNT_A: begin
                if (!a_req) begin
                    state_d = IDLE;
                end else if (de_ack) begin
                    count_d = count_sat;
                    if (b_req && burst_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            GNT_B: begin
                if (!b_req) begin
                    state_d = IDLE;
                end else if (de_ack) begin
                    count_d = count_sat;
                    if (a_req && burst_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command mux and ack steering from the current owner; IDLE drives a quiet bus.
    always_comb begin
        de_req    = 1'b0;
        de_addr   = '0;
        de_nbyte  = 4'b1111;
        de_rnw    = 1'b1;
        de_w_data = '0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        case (state_q)
            GNT_A: begin
                de_req    = a_req;
                de_addr   = a_addr;
                de_nbyte  = a_nbyte;
                de_rnw    = a_rnw;
                de_w_data = a_w_data;
                a_ack     = de_ack;
            end
            GNT_B: begin
                de_req    = b_req;
                de_addr   = b_addr;
                de_nbyte  = b_nbyte;
                de_rnw    = b_rnw;
                de_w_data = b_w_data;
                b_ack     = de_ack;
            end
            default: begin
            end
        endcase
    end

    // Read data is shared by both ports; grants decode the state register.
    assign r_data  = de_r_data;
    assign grant_a = (state_q == GNT_A);
    assign grant_b = (state_q == GNT_B);

endmodule

// File: tb/tb_de_arbiter.sv
// tb_de_arbiter: directed bench with an expectation queue; BURST=4 and BURST=1 instances.
module tb_de_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, b_req, de_ack;
    logic [17:0] a_addr, b_addr;
    logic [3:0]  a_nbyte, b_nbyte;
    logic        a_rnw, b_rnw;
    logic [31:0] a_w_data, b_w_data, de_r_data;

    logic        a_ack, b_ack, de_req, de_rnw, grant_a, grant_b;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic [31:0] de_w_data, r_data;

    logic        a_req1, b_req1, de_ack1;
    logic        a_ack1, b_ack1, de_req1, de_rnw1, grant_a1, grant_b1;
    logic [17:0] de_addr1;
    logic [3:0]  de_nbyte1;
    logic [31:0] de_w_data1, r_data1;

    int unsigned n_checks;
    int unsigned n_errors;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    de_arbiter #(.BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_ack(a_ack), .a_addr(a_addr), .a_nbyte(a_nbyte),
        .a_rnw(a_rnw), .a_w_data(a_w_data),
        .b_req(b_req), .b_ack(b_ack), .b_addr(b_addr), .b_nbyte(b_nbyte),
        .b_rnw(b_rnw), .b_w_data(b_w_data),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
        .r_data(r_data), .grant_a(grant_a), .grant_b(grant_b)
    );

    de_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req1), .a_ack(a_ack1), .a_addr(a_addr), .a_nbyte(a_nbyte),
        .a_rnw(a_rnw), .a_w_data(a_w_data),
        .b_req(b_req1), .b_ack(b_ack1), .b_addr(b_addr), .b_nbyte(b_nbyte),
        .b_rnw(b_rnw), .b_w_data(b_w_data),
        .de_req(de_req1), .de_ack(de_ack1), .de_addr(de_addr1), .de_nbyte(de_nbyte1),
        .de_rnw(de_rnw1), .de_w_data(de_w_data1), .de_r_data(de_r_data),
        .r_data(r_data1), .grant_a(grant_a1), .grant_b(grant_b1)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expected value for a later comparison.
    task automatic expect_val(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    // Advance one clock; inputs change and outputs settle 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; de_ack = 1'b0;
        a_req1 = 1'b0; b_req1 = 1'b0; de_ack1 = 1'b0;
        a_addr = 18'h0; b_addr = 18'h0; a_nbyte = 4'h0; b_nbyte = 4'h0;
        a_rnw = 1'b1; b_rnw = 1'b1; a_w_data = 32'h0; b_w_data = 32'h0;
        de_r_data = 32'h0;
        step();
        step();

        // Reset: IDLE bus values, no grants.
        a_addr = 18'h3_ffff; a_nbyte = 4'h0; a_rnw = 1'b0; a_w_data = 32'hdead_beef;
        #1;
        expect_val("rst_grant_a", 32'd0);  check(32'(grant_a));
        expect_val("rst_grant_b", 32'd0);  check(32'(grant_b));
        expect_val("rst_de_req", 32'd0);   check(32'(de_req));
        expect_val("rst_de_addr", 32'd0);  check(32'(de_addr));
        expect_val("rst_de_nbyte", 32'hf); check(32'(de_nbyte));
        expect_val("rst_de_rnw", 32'd1);   check(32'(de_rnw));
        expect_val("rst_de_wdata", 32'd0); check(de_w_data);

        // Release reset with both requesting: A wins first, after one cycle.
        step();
        rst = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        expect_val("arb_latency_grant_a", 32'd0); check(32'(grant_a));
        step();
        expect_val("first_grant_a", 32'd1); check(32'(grant_a));
        expect_val("first_grant_b", 32'd0); check(32'(grant_b));

        // Four acks to A, then forced handover through IDLE.
        de_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_val("burst_a_grant", 32'd1); check(32'(grant_a));
            expect_val("burst_a_ack", 32'd1);   check(32'(a_ack));
            expect_val("burst_b_ack", 32'd0);   check(32'(b_ack));
            step();
        end
        expect_val("handover_idle_ga", 32'd0);  check(32'(grant_a));
        expect_val("handover_idle_gb", 32'd0);  check(32'(grant_b));
        expect_val("handover_idle_req", 32'd0); check(32'(de_req));
        expect_val("idle_ack_ignored_a", 32'd0); check(32'(a_ack));
        expect_val("idle_ack_ignored_b", 32'd0); check(32'(b_ack));
        step();
        expect_val("handover_grant_b", 32'd1); check(32'(grant_b));

        // A goes away: B keeps the grant through ten acks, address tracking.
        a_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_addr = 18'(32'h100 + 32'(i) * 32'h11);
            #1;
            expect_val("solo_b_grant", 32'd1); check(32'(grant_b));
            expect_val("solo_b_ack", 32'd1);   check(32'(b_ack));
            expect_val("solo_b_addr", 32'(18'(32'h100 + 32'(i) * 32'h11))); check(32'(de_addr));
            step();
        end
        expect_val("solo_b_after", 32'd1); check(32'(grant_b));
        de_ack = 1'b0;
        b_req = 1'b0;
        step();
        expect_val("b_release_idle", 32'd0); check(32'(grant_b));

        // Command mux from port A.
        a_req = 1'b1; a_addr = 18'h12345; a_nbyte = 4'b1011; a_rnw = 1'b0;
        a_w_data = 32'hcafe_f00d; de_r_data = 32'h1357_9bdf;
        b_addr = 18'h2aaaa; b_nbyte = 4'b0000; b_rnw = 1'b1;
        step();
        expect_val("mux_grant_a", 32'd1);          check(32'(grant_a));
        expect_val("mux_de_req", 32'd1);           check(32'(de_req));
        expect_val("mux_de_addr", 32'h12345);      check(32'(de_addr));
        expect_val("mux_de_nbyte", 32'b1011);      check(32'(de_nbyte));
        expect_val("mux_de_rnw", 32'd0);           check(32'(de_rnw));
        expect_val("mux_de_wdata", 32'hcafe_f00d); check(de_w_data);
        expect_val("r_data_bcast", 32'h1357_9bdf); check(r_data);
        de_ack = 1'b1;
        #1;
        expect_val("mux_a_ack", 32'd1); check(32'(a_ack));
        expect_val("mux_b_ack", 32'd0); check(32'(b_ack));

        // Two acks then A drops: back to IDLE, then re-grant.
        step();
        step();
        expect_val("a_two_acks_grant", 32'd1); check(32'(grant_a));
        de_ack = 1'b0;
        a_req = 1'b0;
        step();
        expect_val("a_drop_grant", 32'd0);   check(32'(grant_a));
        expect_val("a_drop_de_req", 32'd0);  check(32'(de_req));
        expect_val("a_drop_nbyte", 32'hf);   check(32'(de_nbyte));
        a_req = 1'b1;
        step();
        expect_val("a_regrant", 32'd1); check(32'(grant_a));

        // Reset mid-GNT_B with an ack in flight.
        a_req = 1'b0;
        step();
        b_req = 1'b1;
        step();
        expect_val("pre_rst_grant_b", 32'd1); check(32'(grant_b));
        de_ack = 1'b1;
        #1;
        expect_val("pre_rst_b_ack", 32'd1); check(32'(b_ack));
        rst = 1'b1;
        a_req = 1'b1;
        #1;
        expect_val("mid_rst_b_ack", 32'd0);   check(32'(b_ack));
        expect_val("mid_rst_grant_b", 32'd0); check(32'(grant_b));
        expect_val("mid_rst_de_req", 32'd0);  check(32'(de_req));
        step();
        rst = 1'b0;
        de_ack = 1'b0;
        step();
        expect_val("post_rst_grant_a", 32'd1); check(32'(grant_a));
        expect_val("post_rst_grant_b", 32'd0); check(32'(grant_b));

        // BURST=1: strict A, IDLE, B, IDLE alternation with one ack each.
        a_req1 = 1'b1; b_req1 = 1'b1; de_ack1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            expect_val("b1_grant_a", (i % 4 == 0) ? 32'd1 : 32'd0); check(32'(grant_a1));
            expect_val("b1_grant_b", (i % 4 == 2) ? 32'd1 : 32'd0); check(32'(grant_b1));
            expect_val("b1_a_ack",   (i % 4 == 0) ? 32'd1 : 32'd0); check(32'(a_ack1));
            expect_val("b1_b_ack",   (i % 4 == 2) ? 32'd1 : 32'd0); check(32'(b_ack1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
